cart_loader: RTL and testbench

CART_LOADER -- requirements
Module: cart_loader

---
 rtl/mp1000_pkg.sv | 34 +++
 rtl/cart_mirror_copy.sv | 52 +++++
 rtl/cart_loader.sv | 177 +++++++++++++++++
 tb/tb_cart_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp1000_pkg.sv
// mp1000_pkg: shared types and constants for the cartridge loader.
//   cart_state_e   : loader FSM states
//   CART_MAX       : largest cartridge image in bytes
//   CART_*_DEF     : default ioctl index / memory base of a cartridge image
//   mirror_unit()  : mirror unit size for a given image size (0 = no mirror)
package mp1000_pkg;

  localparam int unsigned CART_MAX  = 8192;
  localparam int unsigned CART_AW   = 13;
  localparam int unsigned SIZE_W    = 14;
  localparam int unsigned MEM_AW    = 16;
  localparam int unsigned IOCTL_AW  = 25;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned INDEX_W   = 8;

  localparam logic [INDEX_W-1:0] CART_INDEX_DEF = 8'd1;
  localparam logic [MEM_AW-1:0]  CART_BASE_DEF  = 16'h8000;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    MIRROR_RD = 3'd2,
    MIRROR_WR = 3'd3,
    DONE      = 3'd4
  } cart_state_e;

  // Small images are replicated across the full window in 2 KiB or 4 KiB units.
  function automatic logic [CART_AW-1:0] mirror_unit(input logic [SIZE_W-1:0] size);
    if (size <= 14'd2048)      return 13'd2048;
    else if (size <= 14'd4096) return 13'd4096;
    else                       return 13'd0;
  endfunction

endpackage

// File: rtl/cart_mirror_copy.sv
// cart_mirror_copy: byte index and address generation for the mirror copy.
//   clk_sys, reset : clock, synchronous active-high reset
//   start_i        : load index with unit_i and latch the unit mask
//   unit_i         : mirror unit size (2048 or 4096)
//   step_i         : advance index by one byte (asserted on the write beat)
//   rd_off_o       : source offset (index folded into the unit)
//   wr_off_o       : destination offset (the index itself)
//   last_o         : index is at the final byte of the cartridge window
module cart_mirror_copy
  import mp1000_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               start_i,
  input  logic [CART_AW-1:0] unit_i,
  input  logic               step_i,
  output logic [CART_AW-1:0] rd_off_o,
  output logic [CART_AW-1:0] wr_off_o,
  output logic               last_o
);

  logic [CART_AW-1:0] i_q, i_d;
  logic [CART_AW-1:0] mask_q, mask_d;

  // Index/mask next-state.
  always_comb begin
    i_d    = i_q;
    mask_d = mask_q;
    if (start_i) begin
      i_d    = unit_i;
      mask_d = unit_i - 13'd1;
    end else if (step_i) begin
      i_d = i_q + 13'd1;
    end
  end

  // Index/mask registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      i_q    <= '0;
      mask_q <= '0;
    end else begin
      i_q    <= i_d;
      mask_q <= mask_d;
    end
  end

  assign rd_off_o = i_q & mask_q;
  assign wr_off_o = i_q;
  assign last_o   = (i_q == 13'(CART_MAX - 1));

endmodule

// File: rtl/cart_loader.sv
// cart_loader: writes a downloaded cartridge image into memory and optionally
// mirrors small images across the 8 KiB cartridge window.
// Build option: define CART_MIRROR_EN to enable the mirror phase; without it
// a download goes straight from LOAD to DONE and mem_q is not consulted.
//   clk_sys, reset        : clock, synchronous active-high reset
//   ioctl_download/index  : download in progress / image type
//   ioctl_wr/addr/dout    : byte strobe, byte offset, byte data
//   mem_q                 : memory read data (one cycle after mem_addr)
//   mem_we/addr/din       : memory write port (combinational during LOAD)
//   cpu_hold              : CPU held in reset while busy
//   cart_loaded           : a non-empty image has been loaded
//   cart_size             : bytes received (highest offset + 1, max 8192)
//   oversize              : bytes beyond 8 KiB were dropped
module cart_loader
  import mp1000_pkg::*;
#(
  parameter logic [INDEX_W-1:0] CART_INDEX = CART_INDEX_DEF,
  parameter logic [MEM_AW-1:0]  CART_BASE  = CART_BASE_DEF
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic [INDEX_W-1:0]  ioctl_index,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [DATA_W-1:0]   ioctl_dout,
  input  logic [DATA_W-1:0]   mem_q,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  output logic                cpu_hold,
  output logic                cart_loaded,
  output logic [SIZE_W-1:0]   cart_size,
  output logic                oversize
);

  cart_state_e        state_q, state_d;
  logic [SIZE_W-1:0]  size_q, size_d;
  logic               over_q, over_d;
  logic               loaded_q, loaded_d;

  logic               mir_start, mir_step;
  logic [CART_AW-1:0] mir_unit;
  logic [CART_AW-1:0] mir_rd_off, mir_wr_off;
  logic               mir_last;

  logic               cart_hit;
  logic               in_range;
  logic [SIZE_W-1:0]  wr_end;

  assign cart_hit = ioctl_download && (ioctl_index == CART_INDEX);
  assign in_range = (ioctl_addr < 25'(CART_MAX));
  // Offset+1 of an in-range byte never exceeds 8192, so the max() saturates.
  assign wr_end   = 14'(ioctl_addr[CART_AW-1:0]) + 14'd1;

  cart_mirror_copy u_mirror (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start_i  (mir_start),
    .unit_i   (mir_unit),
    .step_i   (mir_step),
    .rd_off_o (mir_rd_off),
    .wr_off_o (mir_wr_off),
    .last_o   (mir_last)
  );

  // Next-state and memory port.
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    over_d    = over_q;
    loaded_d  = loaded_q;
    mir_start = 1'b0;
    mir_step  = 1'b0;
    mir_unit  = '0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;

    unique case (state_q)
      IDLE: begin
        if (cart_hit) begin
          state_d  = LOAD;
          size_d   = '0;
          over_d   = 1'b0;
          loaded_d = 1'b0;
        end
      end

      LOAD: begin
        if (ioctl_wr) begin
          if (in_range) begin
            mem_we   = 1'b1;
            mem_addr = CART_BASE + 16'(ioctl_addr[CART_AW-1:0]);
            mem_din  = ioctl_dout;
            if (wr_end > size_q) size_d = wr_end;
          end else begin
            over_d = 1'b1;
          end
        end
        // Download end; a byte arriving on the same cycle still counts.
        if (!ioctl_download) begin
          state_d = DONE;
`ifdef CART_MIRROR_EN
          if (size_d != '0 && mirror_unit(size_d) != '0) begin
            state_d   = MIRROR_RD;
            mir_start = 1'b1;
            mir_unit  = mirror_unit(size_d);
          end
`endif
        end
      end

      MIRROR_RD: begin
        if (cart_hit) begin
          state_d  = LOAD;
          size_d   = '0;
          over_d   = 1'b0;
          loaded_d = 1'b0;
        end else begin
          mem_addr = CART_BASE + 16'(mir_rd_off);
          state_d  = MIRROR_WR;
        end
      end

      MIRROR_WR: begin
        if (cart_hit) begin
          state_d  = LOAD;
          size_d   = '0;
          over_d   = 1'b0;
          loaded_d = 1'b0;
        end else begin
          mem_we   = 1'b1;
          mem_addr = CART_BASE + 16'(mir_wr_off);
          mem_din  = mem_q;
          mir_step = 1'b1;
          state_d  = mir_last ? DONE : MIRROR_RD;
        end
      end

      DONE: begin
        loaded_d = (size_q != '0);
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Reset suppresses any write in the cycle it is asserted.
    if (reset) begin
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
    end
  end

  // State and status registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      size_q   <= '0;
      over_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      over_q   <= over_d;
      loaded_q <= loaded_d;
    end
  end

  assign cpu_hold    = (state_q != IDLE);
  assign cart_loaded = loaded_q;
  assign cart_size   = size_q;
  assign oversize    = over_q;

endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: scoreboard bench for cart_loader. Mirror-phase expectations
// are compiled in when CART_MIRROR_EN is defined, matching the DUT build.
`timescale 1ns/1ps
module tb_cart_loader;
  import mp1000_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  mem_q;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        cpu_hold;
  logic        cart_loaded;
  logic [13:0] cart_size;
  logic        oversize;

  cart_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .mem_q          (mem_q),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .cpu_hold       (cpu_hold),
    .cart_loaded    (cart_loaded),
    .cart_size      (cart_size),
    .oversize       (oversize)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model: synchronous read, one cycle latency.
  logic [7:0] mem [0:65535];
  always @(posedge clk_sys) begin
    mem_q <= mem[mem_addr];
    if (mem_we === 1'b1) mem[mem_addr] = mem_din;
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] exp_img [0:8191];
  int         exp_size;
  int         we_count;
  int         hi_count;
  int         mid_count;
  int         hold_count;

  // Write monitor: every observed write must be the next expected one.
  always @(negedge clk_sys) begin
    if (cpu_hold === 1'b1) hold_count++;
    if (mem_we === 1'b1) begin
      we_count++;
      if (mem_addr > 16'h87FF) hi_count++;
      if (mem_addr >= 16'h83E8 && mem_addr <= 16'h87FF) mid_count++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_we", 32'(mem_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(e.addr));
        check_eq("wr_data", 32'(mem_din), 32'(e.data));
        if (e.addr >= 16'h8000 && e.addr <= 16'h9FFF) exp_img[e.addr - 16'h8000] = e.data;
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Expected cycles from download end until cpu_hold drops.
  function automatic int exp_cycles(input int size);
    int unit;
    unit = 0;
`ifdef CART_MIRROR_EN
    if (size != 0) unit = (size <= 2048) ? 2048 : ((size <= 4096) ? 4096 : 0);
`endif
    if (unit != 0) return 2 * (8192 - unit) + 2;
    return 2;
  endfunction

  task automatic download(input logic [7:0] idx, input int n);
    bit hit;
    hit = (idx == CART_INDEX_DEF);
    if (hit) exp_size = 0;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    step();
    for (int a = 0; a < n; a++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(a);
      ioctl_dout = 8'(a);
      if (hit && a < 8192) begin
        exp_q.push_back({16'(32'h8000 + a), 8'(a)});
        if (a + 1 > exp_size) exp_size = a + 1;
      end
      step();
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
`ifdef CART_MIRROR_EN
    if (hit && exp_size != 0) begin
      int unit;
      unit = (exp_size <= 2048) ? 2048 : ((exp_size <= 4096) ? 4096 : 0);
      if (unit != 0)
        for (int i = unit; i < 8192; i++)
          exp_q.push_back({16'(32'h8000 + i), exp_img[i & (unit - 1)]});
    end
`endif
  endtask

  task automatic wait_idle(input string tag, input int exp_cyc);
    int cyc;
    cyc = 0;
    while (cpu_hold !== 1'b0 && cyc < 20000) begin
      step();
      cyc++;
    end
    if (cyc >= 20000) check_eq({tag, "_timeout"}, 32'(cpu_hold), 32'd0);
    else              check_eq({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check_eq({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int we0;
    int n;
    for (int k = 0; k < 65536; k++) mem[k] = 8'hA5;
    for (int k = 0; k < 8192; k++) exp_img[k] = 8'hA5;
    exp_size = 0; we_count = 0; hi_count = 0; mid_count = 0; hold_count = 0;
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;

    // Reset state
    step(); step();
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_din", 32'(mem_din), 32'd0);
    check_eq("rst_hold", 32'(cpu_hold), 32'd0);
    check_eq("rst_loaded", 32'(cart_loaded), 32'd0);
    check_eq("rst_size", 32'(cart_size), 32'd0);
    check_eq("rst_over", 32'(oversize), 32'd0);
    reset = 1'b0;
    step();

    // 2048-byte image
    hi_count = 0;
    ioctl_index = CART_INDEX_DEF; ioctl_download = 1'b1;
    download(CART_INDEX_DEF, 2048);
    check_eq("b_hold_busy", 32'(cpu_hold), 32'd1);
    wait_idle("b", exp_cycles(2048));
    check_eq("b_size", 32'(cart_size), 32'd2048);
    check_eq("b_loaded", 32'(cart_loaded), 32'd1);
    check_eq("b_over", 32'(oversize), 32'd0);
`ifdef CART_MIRROR_EN
    check_eq("b_mem_9800", 32'(mem[16'h9800]), 32'h00);
    check_eq("b_mem_9FFF", 32'(mem[16'h9FFF]), 32'hFF);
`else
    check_eq("b_hi_writes", 32'(hi_count), 32'd0);
    check_eq("b_mem_9800", 32'(mem[16'h9800]), 32'hA5);
`endif

    // 5000-byte image: no mirror
    download(CART_INDEX_DEF, 5000);
    wait_idle("c", 2);
    check_eq("c_size", 32'(cart_size), 32'd5000);
    check_eq("c_loaded", 32'(cart_loaded), 32'd1);

    // 9000-byte image: truncated at 8 KiB
    we0 = we_count;
    download(CART_INDEX_DEF, 9000);
    wait_idle("d", 2);
    check_eq("d_writes", 32'(we_count - we0), 32'd8192);
    check_eq("d_size", 32'(cart_size), 32'd8192);
    check_eq("d_over", 32'(oversize), 32'd1);

    // Foreign index: ignored entirely
    we0 = we_count; hold_count = 0;
    download(8'd0, 50);
    step(); step();
    check_eq("e_writes", 32'(we_count - we0), 32'd0);
    check_eq("e_hold_cycles", 32'(hold_count), 32'd0);
    check_eq("e_loaded", 32'(cart_loaded), 32'd1);
    check_eq("e_size", 32'(cart_size), 32'd8192);
    check_eq("e_over", 32'(oversize), 32'd1);

    // Empty download
    download(CART_INDEX_DEF, 0);
    wait_idle("g", 2);
    check_eq("g_loaded", 32'(cart_loaded), 32'd0);
    check_eq("g_size", 32'(cart_size), 32'd0);

    // Reset in the middle of LOAD, coincident with a byte strobe
    ioctl_index = CART_INDEX_DEF; ioctl_download = 1'b1;
    step();
    for (int a = 0; a < 10; a++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = 8'(a + 8'h40);
      exp_q.push_back({16'(32'h8000 + a), 8'(a + 8'h40)});
      step();
    end
    ioctl_addr = 25'd10; ioctl_dout = 8'h77; reset = 1'b1;
    @(negedge clk_sys);
    check_eq("h_we_in_reset", 32'(mem_we), 32'd0);
    step();
    reset = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
    #1;
    check_eq("h_hold", 32'(cpu_hold), 32'd0);
    check_eq("h_size", 32'(cart_size), 32'd0);
    check_eq("h_addr", 32'(mem_addr), 32'd0);
    check_eq("h_sb_empty", 32'(exp_q.size()), 32'd0);
    step();

`ifdef CART_MIRROR_EN
    // Reset during the mirror write at i=0x1000, then reload 1000 bytes
    download(CART_INDEX_DEF, 1000);
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr == 16'h8FFF) && n < 20000) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 20000) check_eq("f_reach_timeout", 32'(mem_addr), 32'h8FFF);
    @(posedge clk_sys);
    step();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk_sys);
    check_eq("f_we_in_reset", 32'(mem_we), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check_eq("f_we", 32'(mem_we), 32'd0);
    check_eq("f_addr", 32'(mem_addr), 32'd0);
    check_eq("f_din", 32'(mem_din), 32'd0);
    check_eq("f_hold", 32'(cpu_hold), 32'd0);
    check_eq("f_loaded", 32'(cart_loaded), 32'd0);
    check_eq("f_size", 32'(cart_size), 32'd0);
    check_eq("f_over", 32'(oversize), 32'd0);
    step();
    mid_count = 0;
    download(CART_INDEX_DEF, 1000);
    wait_idle("f2", exp_cycles(1000));
    check_eq("f2_untouched", 32'(mid_count), 32'd0);
    check_eq("f2_size", 32'(cart_size), 32'd1000);
    check_eq("f2_loaded", 32'(cart_loaded), 32'd1);
    check_eq("f2_mem_8800", 32'(mem[16'h8800]), 32'h00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
